// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioning blocks:
//   - btn_state_t : 2-bit debouncer FSM state encoding
//   - IDLE / PRESS_WAIT / PRESSED / RELEASE_WAIT state constants
//   - default timing constants for DB_CYCLES, REPEAT_DELAY, REPEAT_RATE
//     (values assume a 100 MHz system clock)
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t IDLE         = 2'd0;
    localparam btn_state_t PRESS_WAIT   = 2'd1;
    localparam btn_state_t PRESSED      = 2'd2;
    localparam btn_state_t RELEASE_WAIT = 2'd3;

    // 10 ms debounce window
    localparam int unsigned DB_CYCLES_DEFAULT    = 1_000_000;
    // 500 ms before the first auto-repeat, then every 100 ms
    localparam int unsigned REPEAT_DELAY_DEFAULT = 50_000_000;
    localparam int unsigned REPEAT_RATE_DEFAULT  = 10_000_000;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input bit. Both stages
// reset to 0. Reused by any block that samples an async input.
// Ports:
//   clk     in  : destination clock, rising edge
//   reset_p in  : asynchronous active-high reset
//   d       in  : asynchronous input
//   q       out : synchronized output (second stage)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic reset_p,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Turns a raw mechanical push-button into a debounced level plus one-cycle
// press/release pulses. btn_pedge is used downstream as the clock enable
// that steps the LED shift/counter stages once per physical press.
//
// Optional feature macro: BTN_REPEAT_EN
//   defined   : btn_repeat pulses after REPEAT_DELAY cycles held, then every
//               REPEAT_RATE cycles while the button stays pressed
//   undefined : btn_repeat is tied to 0 and no repeat counter exists
//
// Parameters:
//   DB_CYCLES    : stable cycles needed to accept a level change (>= 2)
//   REPEAT_DELAY : cycles in PRESSED before the first repeat pulse
//   REPEAT_RATE  : cycles between subsequent repeat pulses
// Ports:
//   clk        in  : system clock, rising edge
//   reset_p    in  : asynchronous active-high reset
//   btn        in  : raw button, asynchronous, 1 = pressed
//   btn_level  out : debounced button state
//   btn_pedge  out : one-cycle pulse on an accepted press
//   btn_nedge  out : one-cycle pulse on an accepted release
//   btn_repeat out : one-cycle auto-repeat pulse
// -----------------------------------------------------------------------------
module button_debouncer
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES    = DB_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEFAULT
) (
    input  logic clk,
    input  logic reset_p,
    input  logic btn,
    output logic btn_level,
    output logic btn_pedge,
    output logic btn_nedge,
    output logic btn_repeat
);

    localparam int unsigned      CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("button_debouncer: DB_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rep
        $error("button_debouncer: REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    logic btn_s;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_p (reset_p),
        .d       (btn),
        .q       (btn_s)
    );

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             pedge_q, pedge_d;
    logic             nedge_q, nedge_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pedge_d = 1'b0;
        nedge_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                // Any 0 during the window is bounce: drop back silently.
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    pedge_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    nedge_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pedge_q <= 1'b0;
            nedge_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pedge_q <= pedge_d;
            nedge_q <= nedge_d;
        end
    end

    assign btn_level = level_q;
    assign btn_pedge = pedge_q;
    assign btn_nedge = nedge_q;

`ifdef BTN_REPEAT_EN
    localparam int unsigned      REP_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                                          : REPEAT_RATE;
    localparam int unsigned      REP_W     = $clog2(REP_MAX) + 1;
    localparam logic [REP_W-1:0] DLY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_armed_q, rep_armed_d;  // first repeat already issued
    logic             repeat_q, repeat_d;

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        repeat_d    = 1'b0;
        if (state_d == PRESSED && state_q != PRESSED) begin
            // Fresh entry (press accepted or release bounce): restart delay.
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (state_q == PRESSED && state_d == PRESSED) begin
            if (rep_cnt_q == (rep_armed_q ? RATE_LAST : DLY_LAST)) begin
                repeat_d    = 1'b1;
                rep_cnt_d   = '0;
                rep_armed_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
            repeat_q    <= repeat_d;
        end
    end

    assign btn_repeat = repeat_q;
`else
    assign btn_repeat = 1'b0;
`endif

endmodule
